// File: rtl/exec_pkg.sv
// exec_pkg: shared constants and types for the execute stage.
//   - default operand/result width, register index width and multiplier iteration count
//   - opcode constants OP_ADD..OP_MUL
//   - FSM state enum and a helper that classifies single-cycle ALU opcodes
package exec_pkg;

  localparam int unsigned EXEC_WIDTH      = 32;
  localparam int unsigned EXEC_AW         = 5;
  localparam int unsigned EXEC_MUL_CYCLES = 32;
  localparam int unsigned OPW             = 4;

  localparam logic [OPW-1:0] OP_ADD = 4'd0;
  localparam logic [OPW-1:0] OP_SUB = 4'd1;
  localparam logic [OPW-1:0] OP_AND = 4'd2;
  localparam logic [OPW-1:0] OP_OR  = 4'd3;
  localparam logic [OPW-1:0] OP_XOR = 4'd4;
  localparam logic [OPW-1:0] OP_SLL = 4'd5;
  localparam logic [OPW-1:0] OP_SRL = 4'd6;
  localparam logic [OPW-1:0] OP_SLT = 4'd7;
  localparam logic [OPW-1:0] OP_MUL = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Opcodes 0..7 complete in one cycle on the ALU.
  function automatic logic is_alu_op(input logic [OPW-1:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/exec_stage_seq_mul.sv
// seq_mul: iterative shift-add multiplier, one partial product per cycle.
//   clk, rst_n        clock, async active-low reset (aborts any multiply)
//   start             load operands, clear accumulator, counter = 0
//   mcand, mplier     operands sampled on start
//   done_c            high during the final iteration cycle
//   product_c         low WIDTH bits of the product, valid while done_c
module seq_mul
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH  = EXEC_WIDTH,
  parameter int unsigned CYCLES = EXEC_MUL_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             done_c,
  output logic [WIDTH-1:0] product_c
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [WIDTH-1:0] acc_next_c;

  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_next_c = mp[0] ? (acc + mc) : acc;
    done_c     = running && (cnt == CW'(CYCLES - 1));
    product_c  = acc_next_c;
  end

  // Iteration registers; upper product bits fall off the left of mc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mc      <= '0;
      mp      <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      mc      <= mcand;
      mp      <= mplier;
    end else if (running) begin
      acc <= acc_next_c;
      mc  <= mc << 1;
      mp  <= mp >> 1;
      cnt <= cnt + CW'(1);
      if (done_c) running <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute stage feeding the register file write port.
//   clk, rst_n              clock, async active-low reset
//   in_valid, in_ready      issue handshake (transfer when both high)
//   op, opa, opb, dest      opcode, operands, destination register
//   wb_en, wb_addr, wb_data registered write-back (wb_en suppressed for dest 0)
//   err                     one-cycle pulse after accepting an illegal opcode
//   busy                    multiplier in progress
// Build option: define EXEC_MUL_EN to execute opcode 8 on the iterative
// multiplier; otherwise opcode 8 is illegal, busy is 0 and in_ready is 1.
module exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH      = EXEC_WIDTH,
  parameter int unsigned AW         = EXEC_AW,
  parameter int unsigned MUL_CYCLES = EXEC_MUL_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [AW-1:0]    dest,
  output logic             wb_en,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             err,
  output logic             busy
);

  logic             accept_c;
  logic             alu_ok_c;
  logic [WIDTH-1:0] alu_res_c;
  logic [4:0]       shamt_c;
  logic             lt_c;

  logic             wb_en_d;
  logic [AW-1:0]    wb_addr_d;
  logic [WIDTH-1:0] wb_data_d;
  logic             err_d;

  assign accept_c = in_valid && in_ready;

  // Single-cycle ALU; only the low five bits of opb form a shift amount.
  always_comb begin
    shamt_c   = opb[4:0];
    lt_c      = $signed(opa) < $signed(opb);
    alu_ok_c  = is_alu_op(op);
    alu_res_c = '0;
    case (op)
      OP_ADD:  alu_res_c = opa + opb;
      OP_SUB:  alu_res_c = opa - opb;
      OP_AND:  alu_res_c = opa & opb;
      OP_OR:   alu_res_c = opa | opb;
      OP_XOR:  alu_res_c = opa ^ opb;
      OP_SLL:  alu_res_c = opa << shamt_c;
      OP_SRL:  alu_res_c = opa >> shamt_c;
      OP_SLT:  alu_res_c = {{(WIDTH-1){1'b0}}, lt_c};
      default: alu_res_c = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  state_e           state;
  state_e           next_state;
  logic [AW-1:0]    dest_q;
  logic             mul_start_c;
  logic             mul_done_c;
  logic [WIDTH-1:0] mul_prod_c;

  seq_mul #(
    .WIDTH  (WIDTH),
    .CYCLES (MUL_CYCLES)
  ) u_seq_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start_c),
    .mcand     (opa),
    .mplier    (opb),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  // Next-state and write-back selection.
  always_comb begin
    next_state  = state;
    mul_start_c = 1'b0;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr;
    wb_data_d   = wb_data;
    err_d       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          if (op == OP_MUL) begin
            mul_start_c = 1'b1;
            next_state  = ST_MUL;
          end else if (alu_ok_c) begin
            wb_en_d   = (dest != '0);
            wb_addr_d = dest;
            wb_data_d = alu_res_c;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done_c) begin
          wb_en_d    = (dest_q != '0);
          wb_addr_d  = dest_q;
          wb_data_d  = mul_prod_c;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register; in_ready/busy registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      dest_q   <= '0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == ST_IDLE);
      busy     <= (next_state == ST_MUL);
      if (mul_start_c) dest_q <= dest;
    end
  end
`else
  assign in_ready = 1'b1;
  assign busy     = 1'b0;

  // Write-back selection: opcode 8 falls into the illegal path here.
  always_comb begin
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr;
    wb_data_d = wb_data;
    err_d     = 1'b0;
    if (accept_c) begin
      if (alu_ok_c) begin
        wb_en_d   = (dest != '0);
        wb_addr_d = dest;
        wb_data_d = alu_res_c;
      end else begin
        err_d = 1'b1;
      end
    end
  end
`endif

  // Write-back and error output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      err     <= 1'b0;
    end else begin
      wb_en   <= wb_en_d;
      wb_addr <= wb_addr_d;
      wb_data <= wb_data_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed vector table, random ALU
// traffic against an arithmetic reference model, and multiply/reset sequences.
module tb_exec_stage;

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [4:0]  dest;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  exec_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .dest     (dest),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model from the opcode rules, using wide plain arithmetic.
  function automatic void model(input logic [3:0] mop, input logic [31:0] a,
                                input logic [31:0] b, output logic legal,
                                output logic [31:0] r);
    longint unsigned la = 64'(a);
    longint unsigned lb = 64'(b);
    longint          sa = a[31] ? longint'(la) - 64'sh1_0000_0000 : longint'(la);
    longint          sb = b[31] ? longint'(lb) - 64'sh1_0000_0000 : longint'(lb);
    logic [4:0]      bs = b[4:0];
    longint unsigned p2 = 64'd1 << bs;
    legal = 1'b1;
    r     = '0;
    case (mop)
      4'd0: r = 32'(la + lb);
      4'd1: r = 32'(la + (64'h1_0000_0000 - lb));
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = 32'(la * p2);
      4'd6: r = 32'(la / p2);
      4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8: begin legal = MUL_EN; r = 32'(la * lb); end
      default: legal = 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        exp_en;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[$];

  // Checks the outputs one cycle after a single-cycle op was issued.
  task automatic check_result(input string tag, input logic [3:0] eop, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] d, input logic valid);
    logic        legal;
    logic [31:0] r;
    model(eop, a, b, legal, r);
    if (!valid) begin
      chk({tag, ".idle_en"}, 32'(wb_en), 32'd0);
      chk({tag, ".idle_err"}, 32'(err), 32'd0);
    end else if (!legal) begin
      chk({tag, ".ill_en"}, 32'(wb_en), 32'd0);
      chk({tag, ".ill_err"}, 32'(err), 32'd1);
    end else begin
      chk({tag, ".en"}, 32'(wb_en), 32'(d != 5'd0));
      chk({tag, ".err"}, 32'(err), 32'd0);
      chk({tag, ".addr"}, 32'(wb_addr), 32'(d));
      chk({tag, ".data"}, wb_data, r);
    end
  endtask

  // Multiply sequence; optionally holds an ADD on the inputs during the multiply.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input bit hold_add);
    int bad = 0;
    logic [31:0] prod = 32'(64'(a) * 64'(b));
    logic [31:0] add_a = 32'($urandom);
    logic [31:0] add_b = 32'($urandom);
    logic [4:0]  add_d = 5'($urandom_range(1, 31));
    op = 4'd8; opa = a; opb = b; dest = d; in_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold_add) begin op = 4'd0; opa = add_a; opb = add_b; dest = add_d; end
        else in_valid = 1'b0;
      end
      if (in_ready !== 1'b0 || busy !== 1'b1 || wb_en !== 1'b0) bad++;
    end
    chk({tag, ".busy_window"}, 32'(bad), 32'd0);
    @(negedge clk);
    chk({tag, ".wb_en"}, 32'(wb_en), 32'(d != 5'd0));
    chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(d));
    chk({tag, ".wb_data"}, wb_data, prod);
    chk({tag, ".ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, ".busy_clear"}, 32'(busy), 32'd0);
    if (hold_add) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, ".b2b_en"}, 32'(wb_en), 32'd1);
      chk({tag, ".b2b_addr"}, 32'(wb_addr), 32'(add_d));
      chk({tag, ".b2b_data"}, wb_data, add_a + add_b);
    end else begin
      @(negedge clk);
      chk({tag, ".single_en"}, 32'(wb_en), 32'd0);
    end
  endtask

  initial begin
    logic [3:0]  p_op = '0;
    logic [31:0] p_a = '0, p_b = '0;
    logic [4:0]  p_d = '0;
    logic        p_v = 1'b0;
    int          hits;

    tbl.push_back('{4'd0, 32'd7, 32'hFFFF_FFFF, 5'd8, 1'b1, 1'b0, 32'd6});
    tbl.push_back('{4'd7, 32'hFFFF_FFFE, 32'd1, 5'd9, 1'b1, 1'b0, 32'd1});
    tbl.push_back('{4'd7, 32'd1, 32'hFFFF_FFFE, 5'd9, 1'b1, 1'b0, 32'd0});
    tbl.push_back('{4'd5, 32'd1, 32'h0000_0024, 5'd3, 1'b1, 1'b0, 32'h10});
    tbl.push_back('{4'd5, 32'd1, 32'h0000_0024, 5'd0, 1'b0, 1'b0, 32'h10});
    tbl.push_back('{4'd1, 32'd5, 32'd7, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFE});
    tbl.push_back('{4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0, 32'd1});
    tbl.push_back('{4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd4, 1'b1, 1'b0, 32'hF000_F000});
    tbl.push_back('{4'd3, 32'hF0F0_F0F0, 32'h0F00_0F00, 5'd5, 1'b1, 1'b0, 32'hFFF0_FFF0});
    tbl.push_back('{4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'd6, 1'b1, 1'b0, 32'h5555_5555});
    tbl.push_back('{4'd12, 32'd1, 32'd2, 5'd7, 1'b0, 1'b1, 32'd0});
    if (!MUL_EN) tbl.push_back('{4'd8, 32'd3, 32'd4, 5'd7, 1'b0, 1'b1, 32'd0});

    rst_n = 1'b0; in_valid = 1'b0; op = '0; opa = '0; opb = '0; dest = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.wb_en", 32'(wb_en), 32'd0);
    chk("rst.wb_addr", 32'(wb_addr), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: issue, then check on the following cycle.
    for (int i = 0; i < tbl.size(); i++) begin
      op = tbl[i].op; opa = tbl[i].a; opb = tbl[i].b; dest = tbl[i].dest; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("tbl%0d.en", i), 32'(wb_en), 32'(tbl[i].exp_en));
      chk($sformatf("tbl%0d.err", i), 32'(err), 32'(tbl[i].exp_err));
      if (!tbl[i].exp_err) begin
        chk($sformatf("tbl%0d.addr", i), 32'(wb_addr), 32'(tbl[i].dest));
        chk($sformatf("tbl%0d.data", i), wb_data, tbl[i].exp_data);
      end
    end
    @(negedge clk);
    chk("tbl.tail_en", 32'(wb_en), 32'd0);
    chk("tbl.tail_err", 32'(err), 32'd0);

    // Random back-to-back traffic; MUL is exercised separately.
    for (int i = 0; i < 300; i++) begin
      if (i > 0) check_result($sformatf("rnd%0d", i - 1), p_op, p_a, p_b, p_d, p_v);
      p_v  = ($urandom_range(0, 3) != 0);
      p_op = 4'($urandom_range(0, 15));
      if (MUL_EN && p_op == 4'd8) p_op = 4'd0;
      p_a  = 32'($urandom);
      p_b  = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      p_d  = 5'($urandom_range(0, 31));
      op = p_op; opa = p_a; opb = p_b; dest = p_d; in_valid = p_v;
      @(posedge clk);
      @(negedge clk);
    end
    check_result("rnd_last", p_op, p_a, p_b, p_d, p_v);
    in_valid = 1'b0;
    @(negedge clk);

`ifdef EXEC_MUL_EN
    do_mul("mul_plan", 32'h0001_0001, 32'h0001_0001, 5'd4, 1'b1);
    do_mul("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b0);
    do_mul("mul_zero", 32'h1234_5678, 32'd0, 5'd12, 1'b0);
    do_mul("mul_dest0", 32'd6, 32'd7, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      do_mul($sformatf("mul_rnd%0d", i), 32'($urandom), 32'($urandom),
             5'($urandom_range(1, 31)), bit'(i % 2));
`endif

    // Reset ten cycles into an opcode-8 operation.
    op = 4'd8; opa = 32'd9; opb = 32'd9; dest = 5'd13; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.wb_en", 32'(wb_en), 32'd0);
    chk("midrst.wb_data", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wb_en !== 1'b0 || busy !== 1'b0) hits++;
    end
    chk("midrst.no_wb_after", 32'(hits), 32'd0);
    chk("midrst.ready_after", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
